truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//   Upstream driver and downstream checker for a 2-input combinational gate under test (e.g. NOR, s = ~a & ~b).
//   Drives minterms m = 0..3 onto a,b and waits SETTLE cycles at each one.
//   Captures the gate output s into a 4-bit truth table and flags whether the table equals EXPECTED.
//   Replaces hand-written #1 stimulus with a clocked, self-checking sweep.
// PARAMETERS
//   EXPECTED  4'b0001  expected truth table, bit m = s for minterm m (default: NOR)
//   SETTLE    1        drive cycles per minterm before sampling; legal range 1..15
// PORTS
//   clk     input   1  single clock, all state updates on posedge
//   reset   input   1  synchronous, active-high reset
//   start   input   1  request a sweep; sampled on posedge
//   s       input   1  output of gate under test
//   a       output  1  gate input, MSB of minterm
//   b       output  1  gate input, LSB of minterm
//   m       output  2  minterm currently driven
//   busy    output  1  sweep in progress
//   done    output  1  sweep complete; sticky until next accepted start or reset
//   table   output  4  captured truth table, bit m = sampled s
//   match   output  1  table == EXPECTED; valid only while done=1
// BEHAVIOUR
//   Clocking and reset
//   - Single clock domain.
//   - Reset is synchronous and active-high; it has priority over every other input.
//   - Reset values: state=IDLE, a=b=0, m=0, busy=0, done=0, table=4'b0000, match=0, settle counter=0.
//   States
//   - IDLE (done=0) and DONE (done=1): outputs are stable.
//     start=1 -> RUN at that edge, with m=0, {a,b}=2'b00, table=0, done=0, match=0, busy=1, cnt=0.
//   - RUN: {a,b} == m at all times.
//     - cnt < SETTLE-1: cnt++, nothing else changes.
//     - cnt == SETTLE-1: table[m] <= s, cnt <= 0.
//       - m < 3: m++ (new minterm drives on the next cycle).
//       - m == 3: go to DONE with busy=0, done=1, m=0, {a,b}=00, and
//         match = ({s,table[2:0]} == EXPECTED), i.e. the final bit is included.
//   Timing
//   - s is sampled only on the last settle edge of each minterm; values of s on earlier cycles are ignored.
//   - If start is accepted at edge k, minterm m is sampled at edge k+(m+1)*SETTLE.
//   - done rises after edge k+4*SETTLE.
//   Start handling
//   - start while busy=1 is ignored (no restart, no queuing).
//   - start held high continuously: a new sweep begins on the edge after DONE is entered.
//   - Reset during RUN aborts the sweep at that edge. All outputs take their reset values and done is not raised.
//   Registers and arithmetic
//   - table, match, a, b, m, busy and done are all registered; none is combinational from s or start.
//   - Settle counter is 4 bits.
//   - m never wraps past 3 inside a sweep.
// TESTING
//   1. Reset asserted for 2 cycles -> a=b=0, m=0, busy=0, done=0, table=0000, match=0.
//   2. NOR gate as s, SETTLE=1, start pulse at edge 0 -> {a,b}=00,01,10,11 on cycles 1..4;
//      done=1 after edge 4; table=4'b0001, match=1.
//   3. s tied to 0 -> table=4'b0000, match=0, done=1 after 4 cycles.
//   4. SETTLE=3 with NOR; s forced to 1 during the first 2 cycles of each minterm ->
//      glitches ignored; table=0001; done after edge 12.
//   5. start pulsed again at edge 2 of a sweep -> ignored, done still after edge 4;
//      reset at edge 2 of a fresh sweep -> all outputs reset at that edge, done never rises.
//   6. From DONE with table=0001, swap in an AND gate and pulse start -> done=0 next edge;
//      sweep yields table=4'b1000, match=0.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Clocked stimulus driver and checker for a 2-input combinational gate:
// sweeps minterms 0..3, samples the gate after SETTLE cycles each, compares against EXPECTED.
module truth_table_sequencer #(
    parameter logic [3:0] EXPECTED = 4'b0001,
    parameter int         SETTLE   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic [1:0] m,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic       match
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [3:0] cnt;

    // "table" is a reserved word, so the captured table is exposed as truth_table.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            a           <= 1'b0;
            b           <= 1'b0;
            m           <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 4'b0000;
            match       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt            <= 4'd0;
                        truth_table[m] <= s;
                        if (m != 2'd3) begin
                            m      <= m + 2'd1;
                            {a, b} <= m + 2'd1;
                        end else begin
                            // The last sample is still in flight, so fold s in directly.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            m     <= 2'd0;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            match <= ({s, truth_table[2:0]} == EXPECTED);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state       <= RUN;
                        cnt         <= 4'd0;
                        a           <= 1'b0;
                        b           <= 1'b0;
                        m           <= 2'd0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        truth_table <= 4'b0000;
                        match       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=1 and SETTLE=3) driven by directed
// sweeps, checked every cycle against a timing-based model plus literal expectations.
module tb_truth_table_sequencer;

    localparam int NOR_G  = 0;
    localparam int ZERO_G = 1;
    localparam int AND_G  = 2;

    int checks   = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v [2];
    logic       s_v     [2];
    logic       d_a     [2];
    logic       d_b     [2];
    logic [1:0] d_m     [2];
    logic       d_busy  [2];
    logic       d_done  [2];
    logic [3:0] d_tbl   [2];
    logic       d_match [2];

    int   gate_sel;
    logic ovr_en;
    logic ovr_val;
    logic cmp_en;

    always #5 clk = ~clk;

    function automatic logic gate_fn(input int sel, input logic ga, input logic gb);
        case (sel)
            NOR_G:   return ~ga & ~gb;
            AND_G:   return ga & gb;
            default: return 1'b0;
        endcase
    endfunction

    assign s_v[0] = gate_fn(gate_sel, d_a[0], d_b[0]);
    assign s_v[1] = ovr_en ? ovr_val : gate_fn(gate_sel, d_a[1], d_b[1]);

    truth_table_sequencer #(.EXPECTED(4'b0001), .SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .s(s_v[0]),
        .a(d_a[0]), .b(d_b[0]), .m(d_m[0]), .busy(d_busy[0]), .done(d_done[0]),
        .truth_table(d_tbl[0]), .match(d_match[0])
    );

    truth_table_sequencer #(.EXPECTED(4'b0001), .SETTLE(3)) u3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .s(s_v[1]),
        .a(d_a[1]), .b(d_b[1]), .m(d_m[1]), .busy(d_busy[1]), .done(d_done[1]),
        .truth_table(d_tbl[1]), .match(d_match[1])
    );

    // Model: a sweep is just "edges elapsed since accept"; every SETTLE-th edge captures one minterm.
    int         settle_of [2];
    logic       mod_run   [2];
    int         mod_t     [2];
    logic [1:0] mod_m     [2];
    logic [3:0] mod_tbl   [2];
    logic       mod_done  [2];
    logic       mod_match [2];

    initial begin
        settle_of[0] = 1;
        settle_of[1] = 3;
        for (int i = 0; i < 2; i++) begin
            mod_run[i] = 1'b0; mod_t[i] = 0; mod_m[i] = 2'd0;
            mod_tbl[i] = 4'd0; mod_done[i] = 1'b0; mod_match[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic sm;
            int   idx;
            sm = (i == 1 && ovr_en) ? ovr_val : gate_fn(gate_sel, mod_m[i][1], mod_m[i][0]);
            if (reset) begin
                mod_run[i] = 1'b0; mod_t[i] = 0; mod_m[i] = 2'd0;
                mod_tbl[i] = 4'd0; mod_done[i] = 1'b0; mod_match[i] = 1'b0;
            end else if (!mod_run[i]) begin
                if (start_v[i]) begin
                    mod_run[i] = 1'b1; mod_t[i] = 0; mod_m[i] = 2'd0;
                    mod_tbl[i] = 4'd0; mod_done[i] = 1'b0; mod_match[i] = 1'b0;
                end
            end else begin
                mod_t[i] = mod_t[i] + 1;
                if (mod_t[i] % settle_of[i] == 0) begin
                    idx = mod_t[i] / settle_of[i] - 1;
                    mod_tbl[i][idx] = sm;
                    if (idx == 3) begin
                        mod_run[i]   = 1'b0;
                        mod_done[i]  = 1'b1;
                        mod_m[i]     = 2'd0;
                        mod_match[i] = (mod_tbl[i] == 4'b0001);
                    end else begin
                        mod_m[i] = 2'(idx + 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [10:0] act, exp;
                act = {d_a[i], d_b[i], d_m[i], d_busy[i], d_done[i], d_tbl[i], d_match[i]};
                exp = {mod_m[i], mod_m[i], mod_run[i], mod_done[i], mod_tbl[i], mod_match[i]};
                checks = checks + 1;
                if (act !== exp) begin
                    failures = failures + 1;
                    $display("FAIL cycle_model inst=%0d t=%0t {a,b,m,busy,done,table,match} got=%b want=%b",
                             i, $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int i);
        start_v[i] = 1'b1;
        tick(1);
        start_v[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_v[0] = 1'b0; start_v[1] = 1'b0;
        gate_sel = NOR_G; ovr_en = 1'b0; ovr_val = 1'b0; cmp_en = 1'b0;
        tick(2);
        cmp_en = 1'b1;
        chk("reset_u1", {d_a[0], d_b[0], d_m[0], d_busy[0], d_done[0], d_tbl[0], d_match[0]}, 8'h00);
        chk("reset_u3", {d_a[1], d_b[1], d_m[1], d_busy[1], d_done[1], d_tbl[1], d_match[1]}, 8'h00);
        reset = 1'b0;
        tick(1);

        // NOR sweep, SETTLE=1
        pulse(0);
        chk("nor_busy", {7'd0, d_busy[0]}, 8'd1);
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            chk("nor_ab_seq", {6'd0, d_a[0], d_b[0]}, 8'(c));
            chk("nor_done_early", {7'd0, d_done[0]}, 8'd0);
        end
        tick(1);
        chk("nor_done", {7'd0, d_done[0]}, 8'd1);
        chk("nor_table", {4'd0, d_tbl[0]}, 8'b0001);
        chk("nor_match", {7'd0, d_match[0]}, 8'd1);
        tick(2);

        // s stuck at 0
        gate_sel = ZERO_G;
        pulse(0);
        tick(4);
        chk("zero_table", {4'd0, d_tbl[0]}, 8'b0000);
        chk("zero_match", {7'd0, d_match[0]}, 8'd0);
        chk("zero_done", {7'd0, d_done[0]}, 8'd1);

        // start while busy is ignored
        gate_sel = NOR_G;
        pulse(0);
        tick(1);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        chk("restart_ign_e2", {7'd0, d_done[0]}, 8'd0);
        tick(1);
        chk("restart_ign_e3", {7'd0, d_done[0]}, 8'd0);
        tick(1);
        chk("restart_ign_done", {7'd0, d_done[0]}, 8'd1);
        chk("restart_ign_table", {4'd0, d_tbl[0]}, 8'b0001);

        // swap to AND from DONE
        gate_sel = AND_G;
        pulse(0);
        chk("and_done_clr", {6'd0, d_done[0], d_busy[0]}, 8'b01);
        tick(4);
        chk("and_table", {4'd0, d_tbl[0]}, 8'b1000);
        chk("and_match", {7'd0, d_match[0]}, 8'd0);
        chk("and_done", {7'd0, d_done[0]}, 8'd1);

        // reset aborts a sweep
        gate_sel = NOR_G;
        pulse(0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("abort_outputs", {d_a[0], d_b[0], d_m[0], d_busy[0], d_done[0], d_tbl[0], d_match[0]}, 8'h00);
        tick(6);
        chk("abort_no_done", {7'd0, d_done[0]}, 8'd0);

        // start held high: back-to-back sweeps
        start_v[0] = 1'b1;
        tick(10);
        start_v[0] = 1'b0;
        tick(3);
        chk("held_done", {6'd0, d_done[0], d_busy[0]}, 8'b10);
        chk("held_match", {7'd0, d_match[0]}, 8'd1);

        // SETTLE=3 with glitches on the first two cycles of each minterm
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        pulse(1);
        for (int mi = 0; mi < 4; mi++) begin
            for (int c = 0; c < 3; c++) begin
                ovr_val = (c < 2) ? 1'b1 : (mi == 0);
                if (mi == 3 && c == 2) chk("glitch_done_e11", {7'd0, d_done[1]}, 8'd0);
                tick(1);
            end
        end
        ovr_en = 1'b0;
        chk("glitch_done_e12", {7'd0, d_done[1]}, 8'd1);
        chk("glitch_table", {4'd0, d_tbl[1]}, 8'b0001);
        chk("glitch_match", {7'd0, d_match[1]}, 8'd1);
        tick(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
